to_dec_ascii: RTL and testbench
===============================

Name: to_dec_ascii

Overview:
- Parametrised sequential binary-to-decimal ASCII converter for on-screen numeric readouts in the HDMI/EDID text overlay path.
- Uses a one-cycle-per-bit double-dabble (add-3 then shift) engine with a start/busy/done handshake.
- Adds over the fixed 12-bit/4-digit converter: configurable input width and digit count, optional two's-complement input with a sign character, optional leading-zero blanking, and exact overflow detection with saturation.

Parameters:
- WIDTH, 16, input value width in bits; legal range 4..32.
- DIGITS, 5, number of decimal output characters; legal range 1..10.
- SIGNED, 0, 1 = value is two's complement and sign_char is driven; 0 = unsigned, sign_char is constant space.
- BLANK_LEADING, 1, 1 = leading zeros become space (8'h20), units digit always printed; 0 = zero-padded.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- value  input  WIDTH  binary value, captured on the accepted start edge.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; outputs are valid and updated in this cycle.
- digits_ascii  output  8*DIGITS  ASCII characters; bits [8*DIGITS-1 -: 8] = most significant digit, [7:0] = units.
- sign_char  output  8  '-' (8'h2D) for negative input when SIGNED=1, else ' ' (8'h20).
- overflow  output  1  magnitude exceeded 10^DIGITS-1 for the last result.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy=0; done=0; overflow=0; sign_char=8'h20; every digits_ascii byte = 8'h30; internal BCD, shift and step registers cleared.
- Reset mid-conversion aborts: no done pulse; outputs take reset values.
- States: IDLE -> CONVERT -> FORMAT -> IDLE.
- IDLE: if start=1 at an edge:
  - capture the magnitude (SIGNED=1 and value[WIDTH-1]=1: two's-complement negate; otherwise value unchanged);
  - latch the negative flag; clear BCD, step counter and sticky overflow;
  - go to CONVERT.
- Magnitude width: WIDTH bits, unsigned. The most-negative input -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) with no loss.
- CONVERT: each cycle, add 3 to every BCD nibble >= 5 (combinational), then shift {bcd, mag} left by one.
  - If the post-add-3 top BCD bit is 1 before the shift, set sticky overflow. This condition is exact: overflow is set iff magnitude > 10^DIGITS-1.
  - After exactly WIDTH shifts, go to FORMAT.
- FORMAT (one cycle): register the outputs, pulse done=1, drop busy, return to IDLE.
  - overflow=1: every digit = '9', regardless of BLANK_LEADING.
  - Otherwise each digit = 8'h30 + nibble. With BLANK_LEADING=1, every zero nibble above the first nonzero nibble becomes 8'h20; the units digit is never blanked.
  - sign_char = 8'h2D iff SIGNED=1 and the latched negative flag is set. Negative zero cannot occur.
- Timing:
  - start accepted at edge k: busy=1 after edge k; done=1 and new outputs after edge k+WIDTH+1; latency WIDTH+1 cycles.
  - Next start accepted at edge k+WIDTH+2 at the earliest, i.e. one conversion per WIDTH+2 cycles.
- start is ignored while busy or in FORMAT; it is not queued.
- value changes after the capture edge do not affect the result.
- Between conversions, digits_ascii, sign_char and overflow hold the last result.

Test Plan:
- Defaults; value=1234, start pulse -> done exactly 17 cycles after accept edge; digits_ascii=" 1234", sign_char=' ', overflow=0, busy high 16 cycles.
- Defaults; value=0 -> "    0". Repeat with BLANK_LEADING=0 -> "00000".
- WIDTH=16, DIGITS=4; value=9999 -> "9999", overflow=0. Then value=10000 -> "9999", overflow=1. Then value=65535 -> "9999", overflow=1.
- SIGNED=1, WIDTH=12, DIGITS=4; value=12'h800 -> sign '-', "2048". Then value=12'hFFF -> '-', "   1". Then value=12'h7FF -> ' ', "2047".
- Defaults; start held high continuously with value toggling every cycle -> each result matches the value sampled at its accept edge; accept edges spaced exactly 18 cycles apart.
- Defaults; value=54321, assert rst_n=0 five cycles after accept -> no done pulse; outputs "00000", overflow=0, busy=0. The next start converts correctly.

Source files
------------

// File: rtl/to_dec_ascii.sv
// Sequential binary-to-decimal ASCII converter: double-dabble engine (one bit per cycle)
// with optional signed input, leading-zero blanking and saturating overflow detection.
module to_dec_ascii #(
    parameter int WIDTH         = 16,
    parameter int DIGITS        = 5,
    parameter int SIGNED        = 0,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [8*DIGITS-1:0]   digits_ascii,
    output logic [7:0]            sign_char,
    output logic                  overflow,
    output logic [1:0]            state_dbg
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_FORMAT  = 2'd2
    } state_t;

    // Handshake: start is sampled only in S_IDLE and is never queued; busy is high for
    // exactly the WIDTH shift cycles; done pulses for one cycle with fresh outputs, and
    // digits_ascii/sign_char/overflow then hold until the next done.

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mag_q, mag_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  neg_q, neg_d;
    logic                  ovf_sticky_q, ovf_sticky_d;
    logic                  done_q, done_d;
    logic [8*DIGITS-1:0]   digits_q, digits_d;
    logic [7:0]            sign_q, sign_d;
    logic                  ovf_q, ovf_d;

    logic                  value_neg;
    logic [WIDTH-1:0]      mag_in;
    logic [BCD_W-1:0]      bcd_adj;
    logic [8*DIGITS-1:0]   text_fmt;
    logic                  seen_nz;
    logic [3:0]            nib;

    // Two's-complement negate is exact in WIDTH unsigned bits, including -2^(WIDTH-1).
    assign value_neg = (SIGNED != 0) && value[WIDTH-1];
    assign mag_in    = value_neg ? (~value + WIDTH'(1)) : value;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Zeros above the first nonzero nibble become spaces; the units digit always prints.
    always_comb begin
        text_fmt = '0;
        seen_nz  = 1'b0;
        nib      = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if ((nib != 4'h0) || (i == 0)) begin
                seen_nz = 1'b1;
            end
            if ((BLANK_LEADING != 0) && !seen_nz) begin
                text_fmt[8*i +: 8] = CH_SPACE;
            end else begin
                text_fmt[8*i +: 8] = CH_ZERO | {4'h0, nib};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        step_d       = step_q;
        neg_d        = neg_q;
        ovf_sticky_d = ovf_sticky_q;
        done_d       = 1'b0;
        digits_d     = digits_q;
        sign_d       = sign_q;
        ovf_d        = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mag_d        = mag_in;
                    neg_d        = value_neg;
                    bcd_d        = '0;
                    step_d       = '0;
                    ovf_sticky_d = 1'b0;
                    state_d      = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // A set top bit after add-3 would be shifted out: the result needs DIGITS+1 digits.
                if (bcd_adj[BCD_W-1]) begin
                    ovf_sticky_d = 1'b1;
                end
                bcd_d  = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
                mag_d  = {mag_q[WIDTH-2:0], 1'b0};
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(WIDTH - 1)) begin
                    state_d = S_FORMAT;
                end
            end
            S_FORMAT: begin
                done_d   = 1'b1;
                ovf_d    = ovf_sticky_q;
                digits_d = ovf_sticky_q ? {DIGITS{CH_NINE}} : text_fmt;
                sign_d   = ((SIGNED != 0) && neg_q) ? CH_MINUS : CH_SPACE;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mag_q        <= '0;
            bcd_q        <= '0;
            step_q       <= '0;
            neg_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            done_q       <= 1'b0;
            digits_q     <= {DIGITS{CH_ZERO}};
            sign_q       <= CH_SPACE;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            step_q       <= step_d;
            neg_q        <= neg_d;
            ovf_sticky_q <= ovf_sticky_d;
            done_q       <= done_d;
            digits_q     <= digits_d;
            sign_q       <= sign_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy         = (state_q == S_CONVERT);
    assign done         = done_q;
    assign digits_ascii = digits_q;
    assign sign_char    = sign_q;
    assign overflow     = ovf_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_to_dec_ascii.sv
// Bench for to_dec_ascii: four instances (defaults, zero-padded, 4-digit saturating, signed 12-bit)
// driven from a vector table plus hand-written back-to-back and reset-abort sequences.
module tb_to_dec_ascii;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  start_v;
    logic [15:0] value0, value1, value2;
    logic [11:0] value3;

    logic [3:0]  busy_v, done_v, ovf_v;
    logic [39:0] dig_v [4];
    logic [7:0]  sgn_v [4];
    logic [39:0] digits0, digits1;
    logic [31:0] digits2, digits3;
    logic [1:0]  st0, st1, st2, st3;

    to_dec_ascii u_def (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .value(value0),
        .busy(busy_v[0]), .done(done_v[0]), .digits_ascii(digits0),
        .sign_char(sgn_v[0]), .overflow(ovf_v[0]), .state_dbg(st0)
    );
    to_dec_ascii #(.BLANK_LEADING(0)) u_pad (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .value(value1),
        .busy(busy_v[1]), .done(done_v[1]), .digits_ascii(digits1),
        .sign_char(sgn_v[1]), .overflow(ovf_v[1]), .state_dbg(st1)
    );
    to_dec_ascii #(.WIDTH(16), .DIGITS(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .value(value2),
        .busy(busy_v[2]), .done(done_v[2]), .digits_ascii(digits2),
        .sign_char(sgn_v[2]), .overflow(ovf_v[2]), .state_dbg(st2)
    );
    to_dec_ascii #(.WIDTH(12), .DIGITS(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .value(value3),
        .busy(busy_v[3]), .done(done_v[3]), .digits_ascii(digits3),
        .sign_char(sgn_v[3]), .overflow(ovf_v[3]), .state_dbg(st3)
    );

    assign dig_v[0] = digits0;
    assign dig_v[1] = digits1;
    assign dig_v[2] = {8'h00, digits2};
    assign dig_v[3] = {8'h00, digits3};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int width_of(input int unit);
        return (unit == 3) ? 12 : 16;
    endfunction

    // Independent reference: repeated divide-by-10, then blank leading zeros.
    function automatic logic [39:0] dec_str(input int unsigned v, input int nd);
        logic [39:0] r;
        int unsigned x;
        bit lead;
        r = '0;
        x = v;
        lead = 1'b1;
        for (int i = 0; i < nd; i++) begin
            r[8*i +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        for (int i = nd - 1; i > 0; i--) begin
            if (lead && (r[8*i +: 8] == 8'h30)) r[8*i +: 8] = 8'h20;
            else lead = 1'b0;
        end
        return r;
    endfunction

    task automatic set_value(input int unit, input logic [31:0] val);
        case (unit)
            0: value0 = val[15:0];
            1: value1 = val[15:0];
            2: value2 = val[15:0];
            default: value3 = val[11:0];
        endcase
    endtask

    task automatic run_conv(input int unit, input logic [31:0] val,
                            output logic [39:0] dig, output logic [7:0] sgn, output logic ovf,
                            output int lat, output int bcnt, output bit timed_out);
        @(posedge clk); #1;
        set_value(unit, val);
        start_v[unit] = 1'b1;
        @(posedge clk); #1;
        start_v[unit] = 1'b0;
        set_value(unit, ~val);
        bcnt = int'(busy_v[unit]);
        lat = 0;
        timed_out = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            lat++;
            if (done_v[unit]) begin
                timed_out = 1'b0;
                break;
            end
            bcnt += int'(busy_v[unit]);
        end
        dig = dig_v[unit];
        sgn = sgn_v[unit];
        ovf = ovf_v[unit];
    endtask

    typedef struct {
        int          unit;
        logic [31:0] val;
        logic [39:0] exp_dig;
        logic [7:0]  exp_sign;
        logic        exp_ovf;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    logic [39:0] dig;
    logic [7:0]  sgn;
    logic        ovf;
    int          lat, bcnt;
    bit          tmo;
    logic [15:0] vals [56];
    bit          saw_done;

    initial begin
        vecs[0]  = '{0, 32'd1234,   " 1234",          8'h20, 1'b0};
        vecs[1]  = '{0, 32'd0,      "    0",          8'h20, 1'b0};
        vecs[2]  = '{0, 32'd65535,  "65535",          8'h20, 1'b0};
        vecs[3]  = '{0, 32'd100,    "  100",          8'h20, 1'b0};
        vecs[4]  = '{1, 32'd0,      "00000",          8'h20, 1'b0};
        vecs[5]  = '{1, 32'd42,     "00042",          8'h20, 1'b0};
        vecs[6]  = '{2, 32'd9999,   {8'h00, "9999"},  8'h20, 1'b0};
        vecs[7]  = '{2, 32'd10000,  {8'h00, "9999"},  8'h20, 1'b1};
        vecs[8]  = '{2, 32'd65535,  {8'h00, "9999"},  8'h20, 1'b1};
        vecs[9]  = '{2, 32'd1000,   {8'h00, "1000"},  8'h20, 1'b0};
        vecs[10] = '{2, 32'd7,      {8'h00, "   7"},  8'h20, 1'b0};
        vecs[11] = '{3, 32'h800,    {8'h00, "2048"},  8'h2D, 1'b0};
        vecs[12] = '{3, 32'hFFF,    {8'h00, "   1"},  8'h2D, 1'b0};
        vecs[13] = '{3, 32'h7FF,    {8'h00, "2047"},  8'h20, 1'b0};
        vecs[14] = '{3, 32'h000,    {8'h00, "   0"},  8'h20, 1'b0};
        vecs[15] = '{3, 32'hC18,    {8'h00, "1000"},  8'h2D, 1'b0};
        vecs[16] = '{3, 32'h001,    {8'h00, "   1"},  8'h20, 1'b0};

        // Clock/reset
        rst_n   = 1'b0;
        start_v = '0;
        value0  = '0;
        value1  = '0;
        value2  = '0;
        value3  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits0", 64'(dig_v[0]), 64'("00000"));
        check("rst_digits2", 64'(dig_v[2]), 64'("0000"));
        check("rst_sign3",   64'(sgn_v[3]), 64'(8'h20));
        check("rst_ovf",     64'(ovf_v),    64'(0));
        check("rst_busy",    64'(busy_v),   64'(0));
        check("rst_done",    64'(done_v),   64'(0));
        rst_n = 1'b1;

        // Table-driven conversions
        for (int i = 0; i < NVEC; i++) begin
            run_conv(vecs[i].unit, vecs[i].val, dig, sgn, ovf, lat, bcnt, tmo);
            check($sformatf("vec%0d_timeout", i), 64'(tmo), 64'(0));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(width_of(vecs[i].unit) + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(width_of(vecs[i].unit)));
            check($sformatf("vec%0d_digits", i), 64'(dig), 64'(vecs[i].exp_dig));
            check($sformatf("vec%0d_sign", i), 64'(sgn), 64'(vecs[i].exp_sign));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(done_v[vecs[i].unit]), 64'(0));
            check($sformatf("vec%0d_hold", i), 64'(dig_v[vecs[i].unit]), 64'(vecs[i].exp_dig));
        end

        // start held high, value changing every cycle: accepts every WIDTH+2 = 18 edges
        @(posedge clk); #1;
        vals[0] = 16'($urandom_range(0, 65535));
        value0 = vals[0];
        start_v[0] = 1'b1;
        for (int e = 0; e < 54; e++) begin
            @(posedge clk); #1;
            check($sformatf("cont_done_e%0d", e), 64'(done_v[0]), 64'((e % 18) == 17));
            if ((e % 18) == 17) begin
                check($sformatf("cont_digits_e%0d", e), 64'(dig_v[0]),
                      64'(dec_str(int'(vals[e-17]), 5)));
            end
            vals[e+1] = 16'($urandom_range(0, 65535));
            value0 = vals[e+1];
        end
        start_v[0] = 1'b0;

        // Reset five cycles after accept aborts the conversion
        @(posedge clk); #1;
        value0 = 16'd54321;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy",   64'(busy_v[0]), 64'(0));
        check("abort_digits", 64'(dig_v[0]),  64'("00000"));
        check("abort_ovf",    64'(ovf_v[0]),  64'(0));
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (done_v[0]) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'(0));
        check("abort_digits_held", 64'(dig_v[0]), 64'("00000"));

        run_conv(0, 32'd54321, dig, sgn, ovf, lat, bcnt, tmo);
        check("post_abort_timeout", 64'(tmo), 64'(0));
        check("post_abort_latency", 64'(lat), 64'(17));
        check("post_abort_digits",  64'(dig), 64'("54321"));
        check("post_abort_ovf",     64'(ovf), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
